// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage MIPS pipeline: operand forwarding, load-use and
// branch/jr stalls, and a multi-cycle mult/div sequencer that holds execute.
module hazard_scoreboard #(
   parameter int unsigned REG_W   = 5,
   parameter int unsigned DIV_LAT = 32,
   parameter int unsigned MUL_LAT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] rs_d,
   input  logic [REG_W-1:0] rt_d,
   input  logic             branch_d,
   input  logic             jr_d,
   input  logic [REG_W-1:0] rs_e,
   input  logic [REG_W-1:0] rt_e,
   input  logic [REG_W-1:0] wreg_e,
   input  logic             regwrite_e,
   input  logic             memtoreg_e,
   input  logic             mdu_start_e,
   input  logic             mdu_is_div_e,
   input  logic [REG_W-1:0] wreg_m,
   input  logic             regwrite_m,
   input  logic             memtoreg_m,
   input  logic [REG_W-1:0] wreg_w,
   input  logic             regwrite_w,
   input  logic             exc_flush,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             flush_d,
   output logic             flush_e,
   output logic             flush_m,
   output logic             fwd_a_d,
   output logic             fwd_b_d,
   output logic [1:0]       fwd_a_e,
   output logic [1:0]       fwd_b_e,
   output logic             mdu_busy,
   output logic             mdu_done
);

   localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
   localparam int unsigned CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
   localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 2);
   localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;

   logic start;
   logic lu;
   logic bs;
   logic bs_rs;
   logic bs_rt;
   logic mdu_stall;

   // Register 0 is hardwired, so it never creates a dependency.
   function automatic logic hit(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
      return (src != '0) && (src == dst);
   endfunction

   assign start     = mdu_start_e & ~exc_flush;
   assign lu        = memtoreg_e & regwrite_e & (hit(rs_d, wreg_e) | hit(rt_d, wreg_e));
   assign bs_rs     = (regwrite_e & hit(rs_d, wreg_e)) | (memtoreg_m & hit(rs_d, wreg_m));
   assign bs_rt     = (regwrite_e & hit(rt_d, wreg_e)) | (memtoreg_m & hit(rt_d, wreg_m));
   assign bs        = (branch_d & (bs_rs | bs_rt)) | (jr_d & bs_rs);
   assign mdu_stall = ((state_q == S_IDLE) & start) | (state_q == S_BUSY);

   assign mdu_busy  = (state_q != S_IDLE);
   assign mdu_done  = (state_q == S_DONE);

   // Forward selects, stalls and flushes; reset and exception flush dominate.
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      fwd_a_d = 1'b0;
      fwd_b_d = 1'b0;
      fwd_a_e = 2'b00;
      fwd_b_e = 2'b00;
      if (rst) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
         flush_m = 1'b1;
      end else begin
         fwd_a_d = regwrite_m & hit(rs_d, wreg_m);
         fwd_b_d = regwrite_m & hit(rt_d, wreg_m);
         if (regwrite_m & hit(rs_e, wreg_m))      fwd_a_e = 2'b10;
         else if (regwrite_w & hit(rs_e, wreg_w)) fwd_a_e = 2'b01;
         if (regwrite_m & hit(rt_e, wreg_m))      fwd_b_e = 2'b10;
         else if (regwrite_w & hit(rt_e, wreg_w)) fwd_b_e = 2'b01;
         if (exc_flush) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
         end else begin
            stall_f = lu | bs | mdu_stall;
            stall_d = lu | bs | mdu_stall;
            stall_e = mdu_stall;
            // A held mult/div in E must not be bubbled by a decode hazard.
            flush_e = (lu | bs) & ~mdu_stall;
            flush_m = mdu_stall;
         end
      end
   end

   // Mult/div sequencer: LAT stall cycles, then a one-cycle DONE as it leaves E.
   always_ff @(posedge clk) begin
      if (rst || exc_flush) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (mdu_start_e) begin
                  state_q <= S_BUSY;
                  cnt_q   <= mdu_is_div_e ? DIV_INIT : MUL_INIT;
               end
            end
            S_BUSY: begin
               if (cnt_q == '0) state_q <= S_DONE;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus queues expected output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_scoreboard;

   localparam int unsigned REG_W   = 5;
   localparam int unsigned DIV_LAT = 32;
   localparam int unsigned MUL_LAT = 4;

   logic             clk;
   logic             rst;
   logic [REG_W-1:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
   logic             branch_d, jr_d, regwrite_e, memtoreg_e, mdu_start_e, mdu_is_div_e;
   logic             regwrite_m, memtoreg_m, regwrite_w, exc_flush;
   logic             stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
   logic             fwd_a_d, fwd_b_d, mdu_busy, mdu_done;
   logic [1:0]       fwd_a_e, fwd_b_e;

   typedef struct {
      string       name;
      logic [13:0] v;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   logic [13:0] act;
   assign act = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
                 fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, mdu_busy, mdu_done};

   hazard_scoreboard #(
      .REG_W  (REG_W),
      .DIV_LAT(DIV_LAT),
      .MUL_LAT(MUL_LAT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rs_d        (rs_d),
      .rt_d        (rt_d),
      .branch_d    (branch_d),
      .jr_d        (jr_d),
      .rs_e        (rs_e),
      .rt_e        (rt_e),
      .wreg_e      (wreg_e),
      .regwrite_e  (regwrite_e),
      .memtoreg_e  (memtoreg_e),
      .mdu_start_e (mdu_start_e),
      .mdu_is_div_e(mdu_is_div_e),
      .wreg_m      (wreg_m),
      .regwrite_m  (regwrite_m),
      .memtoreg_m  (memtoreg_m),
      .wreg_w      (wreg_w),
      .regwrite_w  (regwrite_w),
      .exc_flush   (exc_flush),
      .stall_f     (stall_f),
      .stall_d     (stall_d),
      .stall_e     (stall_e),
      .flush_d     (flush_d),
      .flush_e     (flush_e),
      .flush_m     (flush_m),
      .fwd_a_d     (fwd_a_d),
      .fwd_b_d     (fwd_b_d),
      .fwd_a_e     (fwd_a_e),
      .fwd_b_e     (fwd_b_e),
      .mdu_busy    (mdu_busy),
      .mdu_done    (mdu_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected vector; stall_f and stall_d always move together.
   function automatic logic [13:0] ex(input logic s, input logic se, input logic fd,
                                      input logic fe, input logic fm, input logic fad,
                                      input logic fbd, input logic [1:0] fae,
                                      input logic [1:0] fbe, input logic b, input logic dn);
      return {s, s, se, fd, fe, fm, fad, fbd, fae, fbe, b, dn};
   endfunction

   task automatic clear_inputs();
      rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
      wreg_e = '0; wreg_m = '0; wreg_w = '0;
      branch_d = 1'b0; jr_d = 1'b0;
      regwrite_e = 1'b0; memtoreg_e = 1'b0; mdu_start_e = 1'b0; mdu_is_div_e = 1'b0;
      regwrite_m = 1'b0; memtoreg_m = 1'b0; regwrite_w = 1'b0; exc_flush = 1'b0;
   endtask

   // Inputs are already applied; queue the expectation and advance one cycle.
   task automatic step(input string name, input logic [13:0] v);
      exp_t e;
      e.name = name;
      e.v    = v;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (act !== e.v) begin
               errors++;
               $display("FAIL %s: got %b expected %b (sf sd se fd fe fm fad fbd fae fbe busy done)",
                        e.name, act, e.v);
            end
         end
      end
   end

   initial begin : stim
      logic [13:0] z;
      z = '0;
      clear_inputs();
      rst = 1'b1;
      // Matching forward inputs must be masked while in reset.
      rs_e = 5'd5; wreg_m = 5'd5; regwrite_m = 1'b1;
      @(posedge clk);
      #1;
      step("reset", ex(0, 0, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
      rst = 1'b0;
      clear_inputs();
      step("post_reset", z);

      // Forwarding priority and independence
      wreg_m = 5'd5; wreg_w = 5'd5; rs_e = 5'd5; regwrite_m = 1'b1; regwrite_w = 1'b1;
      step("fwd_m_prio", ex(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0));
      regwrite_m = 1'b0;
      step("fwd_w", ex(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0));
      rs_e = 5'd0;
      step("fwd_none", z);
      clear_inputs();
      rs_e = 5'd6; rt_e = 5'd7; wreg_m = 5'd6; regwrite_m = 1'b1;
      wreg_w = 5'd7; regwrite_w = 1'b1; rs_d = 5'd6; rt_d = 5'd7;
      step("fwd_ab_indep", ex(0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b01, 0, 0));
      clear_inputs();
      regwrite_m = 1'b1; regwrite_w = 1'b1; regwrite_e = 1'b1; memtoreg_e = 1'b1;
      memtoreg_m = 1'b1; branch_d = 1'b1;
      step("reg0_never", z);

      // Load-use
      clear_inputs();
      memtoreg_e = 1'b1; regwrite_e = 1'b1; wreg_e = 5'd8; rt_d = 5'd8;
      step("load_use", ex(1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      memtoreg_e = 1'b0;
      step("alu_no_lu", z);
      clear_inputs();
      step("lu_cleared", z);

      // Branch and jr
      branch_d = 1'b1; rs_d = 5'd3; regwrite_e = 1'b1; wreg_e = 5'd3;
      step("branch_e", ex(1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      clear_inputs();
      jr_d = 1'b1; rt_d = 5'd3; rs_d = 5'd4; regwrite_e = 1'b1; wreg_e = 5'd3;
      step("jr_rt_ignored", z);
      clear_inputs();
      jr_d = 1'b1; rs_d = 5'd4; memtoreg_m = 1'b1; regwrite_m = 1'b1; wreg_m = 5'd4;
      step("jr_load_m", ex(1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0));
      clear_inputs();
      branch_d = 1'b1; rt_d = 5'd9; wreg_m = 5'd9; regwrite_m = 1'b1;
      step("branch_fwd_m", ex(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0));
      clear_inputs();

      // Two back-to-back multiplies with start held continuously
      mdu_start_e = 1'b1;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < MUL_LAT; i++)
            step("mul_stall", ex(1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, i != 0, 0));
         step("mul_done", ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1));
      end
      mdu_start_e = 1'b0;
      step("mul_idle", z);

      // Divide
      mdu_start_e = 1'b1; mdu_is_div_e = 1'b1;
      for (int i = 0; i < DIV_LAT; i++)
         step("div_stall", ex(1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, i != 0, 0));
      step("div_done", ex(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1));
      clear_inputs();
      step("div_idle", z);

      // Divide overlapping a load-use: no flush_e until the sequencer releases
      mdu_start_e = 1'b1; mdu_is_div_e = 1'b1;
      memtoreg_e = 1'b1; regwrite_e = 1'b1; wreg_e = 5'd8; rt_d = 5'd8;
      for (int i = 0; i < DIV_LAT; i++)
         step("ovl_stall", ex(1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, i != 0, 0));
      step("ovl_done_lu", ex(1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1));
      clear_inputs();
      step("ovl_idle", z);

      // Exception abort in BUSY
      mdu_start_e = 1'b1; mdu_is_div_e = 1'b1;
      for (int i = 0; i < 10; i++)
         step("exc_pre", ex(1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, i != 0, 0));
      exc_flush = 1'b1;
      step("exc_abort", ex(0, 0, 1, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0));
      clear_inputs();
      for (int i = 0; i < 3; i++) step("exc_no_done", z);

      // Exception with a start present in IDLE: no operation begins
      mdu_start_e = 1'b1; exc_flush = 1'b1;
      memtoreg_e = 1'b1; regwrite_e = 1'b1; wreg_e = 5'd8; rs_d = 5'd8;
      step("exc_idle_start", ex(0, 0, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0));
      clear_inputs();
      step("exc_idle_after", z);

      // Reset abort in BUSY
      mdu_start_e = 1'b1; mdu_is_div_e = 1'b1;
      for (int i = 0; i < 10; i++)
         step("rst_pre", ex(1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, i != 0, 0));
      rst = 1'b1;
      step("rst_abort", ex(0, 0, 1, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0));
      rst = 1'b0;
      clear_inputs();
      for (int i = 0; i < 3; i++) step("rst_no_done", z);

      // Drain the scoreboard with a bounded wait
      for (int k = 0; k < 5 && q.size() != 0; k++) @(posedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
